// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory ready/timeout handshake, illegal-opcode trap and debug state output.
// Define MC_CTRL_EXT_BR_EN to additionally decode bne, j and jr.
module mc_ctrl_fsm #(
  parameter int ALUOP_W = 4,
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Zero,
  input  logic [5:0]         Op,
  input  logic [5:0]         Func,
  input  logic               MemRdy,
  output logic               PCWr,
  output logic               IRWr,
  output logic               RFWr,
  output logic               DMWr,
  output logic               DMRd,
  output logic [1:0]         EXTSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         RegSel,
  output logic [1:0]         WDSel,
  output logic               BSel,
  output logic               IllOp,
  output logic               MemErr,
  output logic [3:0]         State
);

  // ALU operation codes as defined by the datapath's ALU.
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUBU = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
`ifdef MC_CTRL_EXT_BR_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
`endif

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MEMWB = 4'd4,
    S_MW    = 4'd5,
    S_EXE   = 4'd6,
    S_ALUWB = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_ILL   = 4'd10
  } state_t;

  state_t          state_reg, state_next;
  logic [TO_W-1:0] cnt_reg, cnt_next;

  logic       is_rtype, is_lw, is_sw, is_beq, is_jal;
  logic       r_alu_ok, i_alu_ok, alu_ok, ext_signed;
  logic [3:0] r_alu_code, i_alu_code;
  logic       in_wait, timeout;
`ifdef MC_CTRL_EXT_BR_EN
  logic       is_bne, is_j, is_jr;
`endif

  always_comb begin
    is_rtype   = (Op == OP_RTYPE);
    is_lw      = (Op == OP_LW);
    is_sw      = (Op == OP_SW);
    is_beq     = (Op == OP_BEQ);
    is_jal     = (Op == OP_JAL);
    ext_signed = is_lw || is_sw || is_beq || (Op == OP_ADDI);

    r_alu_ok   = 1'b1;
    r_alu_code = 4'd0;
    case (Func)
      6'h21:   r_alu_code = ALU_ADDU;
      6'h23:   r_alu_code = ALU_SUBU;
      6'h20:   r_alu_code = ALU_ADD;
      6'h22:   r_alu_code = ALU_SUB;
      6'h24:   r_alu_code = ALU_AND;
      6'h25:   r_alu_code = ALU_OR;
      6'h26:   r_alu_code = ALU_XOR;
      6'h27:   r_alu_code = ALU_NOR;
      6'h2A:   r_alu_code = ALU_SLT;
      6'h2B:   r_alu_code = ALU_SLTU;
      default: r_alu_ok   = 1'b0;
    endcase

    i_alu_ok   = 1'b1;
    i_alu_code = 4'd0;
    case (Op)
      OP_ORI:   i_alu_code = ALU_OR;
      OP_ADDI:  i_alu_code = ALU_ADD;
      OP_ADDIU: i_alu_code = ALU_ADDU;
      OP_ANDI:  i_alu_code = ALU_AND;
      OP_XORI:  i_alu_code = ALU_XOR;
      default:  i_alu_ok   = 1'b0;
    endcase

    alu_ok = is_rtype ? r_alu_ok : i_alu_ok;
`ifdef MC_CTRL_EXT_BR_EN
    is_bne = (Op == OP_BNE);
    is_j   = (Op == OP_J);
    is_jr  = is_rtype && (Func == FN_JR);
`endif
  end

  assign in_wait = (state_reg == S_FETCH) || (state_reg == S_MR) || (state_reg == S_MW);
  // MemRdy arriving in the same cycle as the limit still completes the access.
  assign timeout = in_wait && !MemRdy && (cnt_reg == TO_W'(TIMEOUT));

  always_comb begin
    state_next = state_reg;
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    RFWr   = 1'b0;
    DMWr   = 1'b0;
    DMRd   = 1'b0;
    EXTSel = 2'd0;
    ALUOp  = '0;
    NPCOp  = 2'd0;
    RegSel = 2'd0;
    WDSel  = 2'd0;
    BSel   = 1'b0;
    IllOp  = 1'b0;
    MemErr = 1'b0;

    case (state_reg)
      S_FETCH: begin
        IRWr = 1'b1;
        PCWr = MemRdy;
        if (MemRdy) state_next = S_DCD;
      end
      S_DCD: begin
        EXTSel = ext_signed ? 2'd1 : 2'd0;
        if (alu_ok)                state_next = S_EXE;
        else if (is_lw || is_sw)   state_next = S_MA;
        else if (is_beq)           state_next = S_BR;
        else if (is_jal)           state_next = S_JMP;
`ifdef MC_CTRL_EXT_BR_EN
        else if (is_bne)           state_next = S_BR;
        else if (is_j || is_jr)    state_next = S_JMP;
`endif
        else                       state_next = S_ILL;
      end
      S_EXE: begin
        BSel       = !is_rtype;
        ALUOp      = ALUOP_W'(is_rtype ? r_alu_code : i_alu_code);
        EXTSel     = (Op == OP_ADDI) ? 2'd1 : 2'd0;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RFWr       = 1'b1;
        RegSel     = is_rtype ? 2'd0 : 2'd1;
        state_next = S_FETCH;
      end
      S_MA: begin
        BSel       = 1'b1;
        EXTSel     = 2'd1;
        ALUOp      = ALUOP_W'(ALU_ADDU);
        state_next = is_sw ? S_MW : S_MR;
      end
      S_MR: begin
        DMRd = 1'b1;
        if (MemRdy) state_next = S_MEMWB;
      end
      S_MW: begin
        DMWr = 1'b1;
        if (MemRdy) state_next = S_FETCH;
      end
      S_MEMWB: begin
        RFWr       = 1'b1;
        RegSel     = 2'd1;
        WDSel      = 2'd1;
        state_next = S_FETCH;
      end
      S_BR: begin
        ALUOp = ALUOP_W'(ALU_SUBU);
        NPCOp = 2'd1;
        PCWr  = Zero;
`ifdef MC_CTRL_EXT_BR_EN
        if (is_bne) PCWr = !Zero;
`endif
        state_next = S_FETCH;
      end
      S_JMP: begin
        PCWr   = 1'b1;
        NPCOp  = 2'd2;
        RFWr   = 1'b1;
        RegSel = 2'd2;
        WDSel  = 2'd2;
`ifdef MC_CTRL_EXT_BR_EN
        if (is_jr) NPCOp = 2'd3;
        if (is_j || is_jr) RFWr = 1'b0;
`endif
        state_next = S_FETCH;
      end
      S_ILL: begin
        IllOp      = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // An abandoned access must leave no architectural side effects.
    if (timeout) begin
      MemErr     = 1'b1;
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RFWr       = 1'b0;
      DMWr       = 1'b0;
      state_next = S_FETCH;
    end
  end

  assign cnt_next = (in_wait && !MemRdy && !timeout && (state_next == state_reg))
                    ? cnt_reg + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign State = state_reg;

endmodule
